// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and bit-period rounding.
// Intended for reuse by a future receiver.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned DataBits = 8;
  localparam int unsigned BitIdxW  = 3;

  // Nearest-integer clocks per bit.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                    input int unsigned baud_rate);
    return (clk_freq_hz + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_tick in the last cycle of every CLKS_PER_BIT-cycle period.
// restart realigns the period so the next bit starts at full length.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = (cnt_q == LastCnt);
    if (restart || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, 1 or 2 stop bits, valid/ready byte input.
// TXD is registered from the next state so it never glitches.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [DataBits-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                busy,
  output logic                TXD
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [BitIdxW-1:0] LastBitIdx = BitIdxW'(DataBits - 1);
  localparam logic StopLast = 1'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e           state_q, state_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [BitIdxW-1:0]  bit_idx_q, bit_idx_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                txd_q, txd_d;

  logic bit_tick;
  logic stop_last;
  logic accept;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .resetn  (resetn),
    .restart (accept),
    .bit_tick(bit_tick)
  );

  // Ready also in the final stop cycle so a waiting producer gets a zero-gap frame.
  assign stop_last = (state_q == StStop) && bit_tick && (stop_cnt_q == StopLast);
  assign tx_ready  = (state_q == StIdle) || stop_last;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != StIdle);
  assign TXD       = txd_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          shift_d    = tx_data;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_idx_q == LastBitIdx) begin
            state_d    = StStop;
            stop_cnt_d = 1'b0;
          end else begin
            shift_d   = {1'b0, shift_q[DataBits-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (stop_cnt_q == StopLast) begin
            if (accept) begin
              state_d    = StStart;
              shift_d    = tx_data;
              bit_idx_d  = '0;
              stop_cnt_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit; one instance with 1 stop bit,
// one with 2 stop bits. Expected bytes go through a scoreboard queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       ready1, busy1, txd1;
  logic       ready2, busy2, txd2;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD_RATE  (100),
    .STOP_BITS  (1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .tx_data (data1),
    .tx_valid(valid1),
    .tx_ready(ready1),
    .busy    (busy1),
    .TXD     (txd1)
  );

  uart_tx #(
    .CLK_FREQ_HZ(1000),
    .BAUD_RATE  (100),
    .STOP_BITS  (2)
  ) dut2 (
    .clk     (clk),
    .resetn  (resetn),
    .tx_data (data2),
    .tx_valid(valid2),
    .tx_ready(ready2),
    .busy    (busy2),
    .TXD     (txd2)
  );

  // Observes one frame starting at the negedge where its first start-bit cycle is visible.
  // Returns the decoded byte and error counts; callers do the comparisons.
  task automatic decode_frame(input int nstop, input int pulse_k, input logic [7:0] pulse_data,
                              output logic [7:0] b, output int busy_hi, output int ready_bad,
                              output int line_bad);
    int   len;
    logic t, bz, rd, cur;
    len = (9 + nstop) * 10;
    b = 8'h00;
    busy_hi = 0;
    ready_bad = 0;
    line_bad = 0;
    cur = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      if (k == pulse_k) begin
        valid1 = 1'b1;
        data1  = pulse_data;
      end
      if (k == pulse_k + 1) valid1 = 1'b0;
      t  = (nstop == 2) ? txd2 : txd1;
      bz = (nstop == 2) ? busy2 : busy1;
      rd = (nstop == 2) ? ready2 : ready1;
      if (bz === 1'b1) busy_hi++;
      if (rd !== (k == len - 1)) ready_bad++;
      if (k < 10 && t !== 1'b0) line_bad++;
      if (k >= 90 && t !== 1'b1) line_bad++;
      if (k >= 10 && k < 90) begin
        if (k % 10 == 0) begin
          cur = t;
          b[k/10-1] = t;
        end else if (t !== cur) begin
          line_bad++;
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    tests_run++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_immediate: txd=%b busy=%b ready=%b, expected 1 0 1", txd1, busy1,
               ready1);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) bad++;
      if (txd2 !== 1'b1 || busy2 !== 1'b0 || ready2 !== 1'b1) bad++;
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) bad++;
      if (txd2 !== 1'b1 || busy2 !== 1'b0 || ready2 !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_hold: %0d bad idle samples, expected 0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] b, e;
    int bh, rb, lb;
    @(negedge clk);
    tests_run++;
    if (ready1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready_idle: ready=%b expected 1", ready1);
    end
    valid1 = 1'b1;
    data1  = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    valid1 = 1'b0;
    data1  = 8'h00;
    tests_run++;
    if (txd1 !== 1'b0 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_latency: txd=%b busy=%b expected 0 1", txd1, busy1);
    end
    decode_frame(1, -10, 8'h00, b, bh, rb, lb);
    e = exp_q.pop_front();
    tests_run++;
    if (b !== e) begin
      tests_failed++;
      $display("FAIL single_byte: got %h expected %h", b, e);
    end
    tests_run++;
    if (bh !== 100) begin
      tests_failed++;
      $display("FAIL single_busy_len: got %0d expected 100", bh);
    end
    tests_run++;
    if (rb !== 0 || lb !== 0) begin
      tests_failed++;
      $display("FAIL single_timing: ready errors %0d line errors %0d, expected 0 0", rb, lb);
    end
    @(negedge clk);
    tests_run++;
    if (busy1 !== 1'b0 || txd1 !== 1'b1 || ready1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_post_idle: busy=%b txd=%b ready=%b expected 0 1 1", busy1, txd1,
               ready1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, e;
    int bh, rb, lb, f1, f2;
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    data1 = 8'h3C;
    exp_q.push_back(8'h3C);
    f1 = cycle;
    decode_frame(1, -10, 8'h00, b, bh, rb, lb);
    e = exp_q.pop_front();
    tests_run++;
    if (b !== e || bh !== 100 || lb !== 0 || rb !== 0) begin
      tests_failed++;
      $display("FAIL b2b_first: byte %h busy %0d line %0d ready %0d, expected %h 100 0 0", b, bh,
               lb, rb, e);
    end
    @(negedge clk);
    valid1 = 1'b0;
    f2 = cycle;
    tests_run++;
    if (f2 - f1 !== 100 || busy1 !== 1'b1 || txd1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: start spacing %0d busy=%b txd=%b, expected 100 1 0", f2 - f1, busy1,
               txd1);
    end
    decode_frame(1, -10, 8'h00, b, bh, rb, lb);
    e = exp_q.pop_front();
    tests_run++;
    if (b !== e || bh !== 100 || lb !== 0 || rb !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second: byte %h busy %0d line %0d ready %0d, expected %h 100 0 0", b, bh,
               lb, rb, e);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] b, e;
    int bh, rb, lb, bad;
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'h00;
    exp_q.push_back(8'h00);
    @(negedge clk);
    valid1 = 1'b0;
    decode_frame(1, 35, 8'hFF, b, bh, rb, lb);
    e = exp_q.pop_front();
    tests_run++;
    if (b !== e || lb !== 0 || bh !== 100) begin
      tests_failed++;
      $display("FAIL ignore_byte: byte %h line %0d busy %0d, expected %h 0 100", b, lb, bh, e);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL ignore_no_second: %0d non-idle cycles, %0d queued, expected 0 0", bad,
               exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b, e;
    int bh, rb, lb;
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'hF0;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (43) @(negedge clk);
    tests_run++;
    if (txd1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_bit3: txd=%b expected 0", txd1);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midframe_abort: txd=%b busy=%b ready=%b expected 1 0 1", txd1, busy1,
               ready1);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'h81;
    exp_q.push_back(8'h81);
    @(negedge clk);
    valid1 = 1'b0;
    decode_frame(1, -10, 8'h00, b, bh, rb, lb);
    e = exp_q.pop_front();
    tests_run++;
    if (b !== e || lb !== 0 || bh !== 100 || rb !== 0) begin
      tests_failed++;
      $display("FAIL midframe_recover: byte %h line %0d busy %0d ready %0d, expected %h 0 100 0",
               b, lb, bh, rb, e);
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] b, e;
    int bh, rb, lb;
    @(negedge clk);
    valid2 = 1'b1;
    data2  = 8'h00;
    exp_q.push_back(8'h00);
    @(negedge clk);
    valid2 = 1'b0;
    decode_frame(2, -10, 8'h00, b, bh, rb, lb);
    e = exp_q.pop_front();
    tests_run++;
    if (b !== e || lb !== 0) begin
      tests_failed++;
      $display("FAIL two_stop_byte: byte %h line %0d, expected %h 0", b, lb, e);
    end
    tests_run++;
    if (bh !== 110 || rb !== 0) begin
      tests_failed++;
      $display("FAIL two_stop_len: busy %0d ready errors %0d, expected 110 0", bh, rb);
    end
    @(negedge clk);
    tests_run++;
    if (busy2 !== 1'b0 || txd2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL two_stop_idle: busy=%b txd=%b expected 0 1", busy2, txd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    test_two_stop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
